// File: rtl/comparator_8b_if.sv
`default_nettype none
// ============================================================================
//  Module      : comparator_8b_if
//  Description : Operand/result bundle for the registered magnitude comparator.
//                master drives operands and reads results; slave is the
//                comparator side.
//  Signals     : A, B         operands
//                in_valid     operands (and signed_mode) sampled when 1
//                signed_mode  0 = unsigned, 1 = two's-complement
//                A_gt_B/A_eq_B/A_lt_B  registered one-hot result flags
//                out_valid    one-cycle strobe marking a fresh result
//  Revision    : 1.0 - initial release
// ============================================================================
interface comparator_8b_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             in_valid;
    logic             signed_mode;
    logic             A_gt_B;
    logic             A_eq_B;
    logic             A_lt_B;
    logic             out_valid;

    modport master (
        output A, B, in_valid, signed_mode,
        input  A_gt_B, A_eq_B, A_lt_B, out_valid
    );

    modport slave (
        input  A, B, in_valid, signed_mode,
        output A_gt_B, A_eq_B, A_lt_B, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/comparator_8b.sv
`default_nettype none
// ============================================================================
//  Module      : comparator_8b
//  Description : Magnitude comparator with registered one-hot result flags and
//                a one-cycle valid strobe. Unsigned or signed per transaction.
//  Ports       : clk    rising-edge clock
//                rst_n  asynchronous active-low reset
//                bus    comparator_8b_if.slave (operands in, flags out)
//  Revision    : 1.0 - initial release
// ============================================================================
module comparator_8b #(
    parameter int WIDTH = 8
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    comparator_8b_if.slave    bus
);

    localparam int c_HALF = WIDTH / 2;

    // Flipping the sign bit maps -128..127 onto 0..255 monotonically, so a
    // plain unsigned compare then gives the signed ordering. Equality is
    // unaffected because both operands get the same flip.
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;

    assign w_a = {bus.A[WIDTH-1] ^ bus.signed_mode, bus.A[WIDTH-2:0]};
    assign w_b = {bus.B[WIDTH-1] ^ bus.signed_mode, bus.B[WIDTH-2:0]};

    // Per-nibble compare: index 1 is the high nibble, index 0 the low one.
    logic [1:0] w_part_gt;
    logic [1:0] w_part_eq;

    for (genvar g = 0; g < 2; g++) begin : g_stage
        assign w_part_gt[g] = (w_a[g*c_HALF +: c_HALF] >  w_b[g*c_HALF +: c_HALF]);
        assign w_part_eq[g] = (w_a[g*c_HALF +: c_HALF] == w_b[g*c_HALF +: c_HALF]);
    end

    // High nibble decides unless it ties; then the low nibble decides.
    logic w_gt;
    logic w_eq;
    logic w_lt;

    assign w_gt = w_part_gt[1] | (w_part_eq[1] & w_part_gt[0]);
    assign w_eq = w_part_eq[1] & w_part_eq[0];
    assign w_lt = ~w_gt & ~w_eq;

    logic r_gt;
    logic r_eq;
    logic r_lt;
    logic r_valid;

    // Flags load only on a valid sample, so idle (possibly X) operands never
    // reach the registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gt    <= 1'b0;
            r_eq    <= 1'b0;
            r_lt    <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_gt <= w_gt;
                r_eq <= w_eq;
                r_lt <= w_lt;
            end
        end
    end

    assign bus.A_gt_B    = r_gt;
    assign bus.A_eq_B    = r_eq;
    assign bus.A_lt_B    = r_lt;
    assign bus.out_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_comparator_8b.sv
`default_nettype none
// ============================================================================
//  Module      : tb_comparator_8b
//  Description : Self-checking bench for comparator_8b. The driver pushes
//                model results into a queue; the monitor pops and compares
//                whenever a result is due one cycle after a valid sample.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_comparator_8b;

    localparam int c_PERIOD = 10;

    logic clk;
    logic rst_n;

    comparator_8b_if #(.WIDTH(8)) bus ();

    comparator_8b #(.WIDTH(8)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #(c_PERIOD/2) clk = ~clk;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [2:0] q_exp[$];          // {gt, eq, lt}
    logic [2:0] r_last = 3'b000;   // flags expected to be held while idle

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: native arithmetic compare, {gt, eq, lt}.
    function automatic logic [2:0] ref_cmp(input logic [7:0] a, input logic [7:0] b, input logic s);
        if (s) begin
            if ($signed(a) > $signed(b))      ref_cmp = 3'b100;
            else if ($signed(a) == $signed(b)) ref_cmp = 3'b010;
            else                               ref_cmp = 3'b001;
        end else begin
            if (a > b)       ref_cmp = 3'b100;
            else if (a == b) ref_cmp = 3'b010;
            else             ref_cmp = 3'b001;
        end
    endfunction

    function automatic logic [2:0] flags();
        flags = {bus.A_gt_B, bus.A_eq_B, bus.A_lt_B};
    endfunction

    // Monitor: decide at each edge whether a result is due, then check #1 later.
    always @(posedge clk) begin
        logic       sampled;
        logic [2:0] e;
        sampled = bus.in_valid && rst_n;
        #1;
        if (!rst_n) begin
            check_val("reset_flags", {29'd0, flags()}, 32'd0);
            check_val("reset_valid", {31'd0, bus.out_valid}, 32'd0);
        end else begin
            check_val("out_valid", {31'd0, bus.out_valid}, {31'd0, sampled});
            if (sampled) begin
                if (q_exp.size() == 0) begin
                    check_val("queue_empty", 32'd1, 32'd0);
                end else begin
                    e = q_exp.pop_front();
                    check_val("result", {29'd0, flags()}, {29'd0, e});
                    r_last = e;
                end
            end else begin
                check_val("hold", {29'd0, flags()}, {29'd0, r_last});
            end
        end
    end

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic s);
        @(negedge clk);
        bus.A           = a;
        bus.B           = b;
        bus.signed_mode = s;
        bus.in_valid    = 1'b1;
        q_exp.push_back(ref_cmp(a, b, s));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.in_valid    = 1'b0;
            bus.A           = 'x;
            bus.B           = 'x;
            bus.signed_mode = 1'bx;
        end
    endtask

    // Watchdog: never let the run hang.
    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Test 1: reset with a valid sample presented, then release.
        rst_n           = 1'b0;
        bus.A           = 8'h00;
        bus.B           = 8'h00;
        bus.signed_mode = 1'b0;
        bus.in_valid    = 1'b1;
        #1;
        check_val("t1_flags_in_reset", {29'd0, flags()}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        q_exp.push_back(3'b010);

        // Tests 2 and 3: sign-sensitive and low-nibble cases.
        drive(8'h80, 8'h7F, 1'b0);
        drive(8'h80, 8'h7F, 1'b1);
        drive(8'hFF, 8'h01, 1'b0);
        drive(8'hFF, 8'h01, 1'b1);
        drive(8'h35, 8'h3A, 1'b0);
        drive(8'h35, 8'h3A, 1'b1);
        drive(8'h7F, 8'h80, 1'b1);
        drive(8'h00, 8'hFF, 1'b1);
        idle(1);

        // Test 4: back-to-back then idle with X operands; lt must hold.
        drive(8'd5, 8'd5, 1'b0);
        drive(8'd9, 8'd3, 1'b0);
        drive(8'd3, 8'd9, 1'b0);
        idle(3);

        // Test 5: reset asserted between edges while results are streaming.
        drive(8'd10, 8'd20, 1'b0);
        drive(8'd20, 8'd10, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_val("t5_async_flags", {29'd0, flags()}, 32'd0);
        check_val("t5_async_valid", {31'd0, bus.out_valid}, 32'd0);
        q_exp.delete();
        r_last = 3'b000;
        @(negedge clk);
        bus.A        = 8'hC0;
        bus.B        = 8'h40;
        bus.in_valid = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        bus.signed_mode = 1'b1;
        q_exp.push_back(ref_cmp(8'hC0, 8'h40, 1'b1));
        drive(8'hC0, 8'h40, 1'b0);
        idle(2);

        // Test 6: sweep all A against a stride of B in both modes.
        for (int m = 0; m < 2; m++) begin
            for (int a = 0; a < 256; a++) begin
                for (int b = 0; b < 256; b += 5) begin
                    drive(a[7:0], b[7:0], m[0]);
                end
                drive(a[7:0], a[7:0], m[0]);
                drive(a[7:0], 8'hFF, m[0]);
            end
        end
        idle(3);

        check_val("queue_drained", q_exp.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
